shift_add_multiplier_8: RTL and testbench



---
 rtl/shift_add_multiplier_8.sv | 141 ++++++++++++++
 tb/tb_shift_add_multiplier_8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_8.sv
// Sequential 8x8 unsigned shift-and-add multiplier plus its 8-bit carry-lookahead adder.
// One partial-product addition per clock; product valid from the done pulse on.

module carry_lookahead_adder_8 (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign g[gi]   = in1[gi] & in2[gi];
      assign p[gi]   = in1[gi] ^ in2[gi];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Each carry is the flattened sum-of-products of generate/propagate terms,
  // so no carry depends on another carry.
  always_comb begin
    logic prop;
    c    = '0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
  end

  assign cout = c[8];

endmodule

module shift_add_multiplier_8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] a_reg;
  logic [7:0] p_reg;
  logic [7:0] q_reg;
  logic [3:0] count_reg;

  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        cout;
  logic [15:0] shifted;

  assign addend = q_reg[0] ? a_reg : 8'h00;

  carry_lookahead_adder_8 u_adder (
    .in1  (p_reg),
    .in2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The adder carry becomes the new MSB of P; Q[0] has been consumed and drops out.
  assign shifted = {cout, sum, q_reg[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      p_reg     <= '0;
      q_reg     <= '0;
      count_reg <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= in1;
            q_reg     <= in2;
            p_reg     <= '0;
            count_reg <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          p_reg     <= shifted[15:8];
          q_reg     <= shifted[7:0];
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd7) begin
            product   <= shifted;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_8.sv
// Directed-vector bench for shift_add_multiplier_8: latency, carry path, ignored start,
// asynchronous abort and back-to-back operation.

module tb_shift_add_multiplier_8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vectors;
  int miscompares;

  shift_add_multiplier_8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op at E0, run E1..E8, check the done pulse and E9 return to idle.
  // With glitch set, a second start carrying 0xFF*0xFF is presented at E3.
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input bit glitch);
    start = 1'b1;
    in1   = a;
    in2   = b;
    tick();
    check_value({name, "_e0_ready"}, {15'd0, ready}, 16'd0);
    check_value({name, "_e0_busy"},  {15'd0, busy},  16'd1);
    in1 = ~a;
    in2 = ~b;
    for (int k = 1; k <= 8; k++) begin
      start = glitch && (k == 3);
      if (start) begin
        in1 = 8'hFF;
        in2 = 8'hFF;
      end
      tick();
      if (k == 7) check_value({name, "_e7_done"}, {15'd0, done}, 16'd0);
    end
    start = 1'b0;
    check_value({name, "_e8_done"},    {15'd0, done}, 16'd1);
    check_value({name, "_e8_busy"},    {15'd0, busy}, 16'd0);
    check_value({name, "_e8_product"}, product,       exp);
    tick();
    check_value({name, "_e9_done"},    {15'd0, done},  16'd0);
    check_value({name, "_e9_ready"},   {15'd0, ready}, 16'd1);
    check_value({name, "_e9_product"}, product,        exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    in1   = 8'h00;
    in2   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_ready",   {15'd0, ready}, 16'd1);
    check_value("reset_busy",    {15'd0, busy},  16'd0);
    check_value("reset_done",    {15'd0, done},  16'd0);
    check_value("reset_product", product,        16'h0000);
    rst = 1'b0;
    tick();

    do_op("basic",  8'h03, 8'h05, 16'h000F, 1'b0);
    do_op("carry",  8'hFF, 8'hFF, 16'hFE01, 1'b0);
    do_op("zero",   8'h00, 8'hA5, 16'h0000, 1'b0);
    do_op("ignore", 8'h0A, 8'h03, 16'h001E, 1'b0 | 1'b1);
    repeat (3) begin
      tick();
      check_value("ignore_no_second_done", {15'd0, done}, 16'd0);
    end

    // Abort between E4 and E5 without waiting for an edge.
    start = 1'b1;
    in1   = 8'h55;
    in2   = 8'h55;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    check_value("abort_product", product,        16'h0000);
    check_value("abort_done",    {15'd0, done},  16'd0);
    check_value("abort_busy",    {15'd0, busy},  16'd0);
    check_value("abort_ready",   {15'd0, ready}, 16'd1);
    tick();
    rst = 1'b0;
    tick();
    do_op("after_abort", 8'hD0, 8'hA0, 16'h8200, 1'b0);

    // Back-to-back with start held high: second op accepted at E10, done at E18.
    start = 1'b1;
    in1   = 8'h80;
    in2   = 8'h02;
    tick();
    in1 = 8'h01;
    in2 = 8'h01;
    for (int k = 1; k <= 18; k++) begin
      tick();
      case (k)
        8:  begin
              check_value("b2b_first_done",    {15'd0, done}, 16'd1);
              check_value("b2b_first_product", product,       16'h0100);
            end
        9:  check_value("b2b_e9_ready",        {15'd0, ready}, 16'd1);
        10: begin
              check_value("b2b_e10_busy",      {15'd0, busy}, 16'd1);
              check_value("b2b_e10_product",   product,       16'h0100);
            end
        17: check_value("b2b_e17_done",        {15'd0, done}, 16'd0);
        18: begin
              check_value("b2b_second_done",    {15'd0, done}, 16'd1);
              check_value("b2b_second_product", product,       16'h0001);
            end
        default: ;
      endcase
    end
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
